data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Data-memory load/store unit for the MIPS datapath. Holds a word-addressed data RAM and
//  executes word/byte loads and stores with a configurable wait-state count. Produces the
//  three load candidates (raw word, sign-extended byte, zero-extended byte) consumed
//  directly by the load-select mux ahead of write-back.
// PARAMETERS
//  ADDR_W       10  byte-address width; RAM depth = 2**(ADDR_W-2) 32-bit words
//  WAIT_CYCLES  1   wait states between request accept and response (0..15)
// PORTS
//  i_clk         in   1       clock; all state updates on rising edge
//  i_rst_n       in   1       reset, asynchronous, active-low
//  i_req         in   1       access request; sampled only while o_ready=1
//  i_we          in   1       1=store, 0=load
//  i_size        in   1       0=word (lw/sw), 1=byte (lb/lbu/sb)
//  i_addr        in   ADDR_W  byte address
//  i_wdata       in   32      store data; byte stores use i_wdata[7:0]
//  o_ready       out  1       unit idle, request will be accepted this cycle
//  o_valid       out  1       one-cycle pulse: access complete
//  o_ram_data    out  32      loaded word
//  o_lb_data     out  32      selected byte, sign-extended
//  o_lbu_data    out  32      selected byte, zero-extended
//  o_misalign    out  1       misaligned word access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, o_ready=1, o_valid=0, o_misalign=0, o_ram_data/o_lb_data/o_lbu_data=0.
//    RAM contents are not reset.
//  - FSM: IDLE -> (i_req) WAIT if WAIT_CYCLES>0, else RESP; WAIT counts WAIT_CYCLES cycles
//    -> RESP; RESP -> IDLE unconditionally. o_ready=1 only in IDLE; o_valid=1 only in RESP.
//  - Accept edge latches i_we, i_size, i_addr, i_wdata; later input changes are ignored.
//    Requests while o_ready=0 are dropped, not queued.
//  - Latency: o_valid asserts WAIT_CYCLES+1 cycles after the accept edge.
//    Back-to-back: next accept no earlier than the cycle after RESP.
//  - Commit edge = edge entering RESP: store written to RAM and load data registered there.
//  - Word index = addr[ADDR_W-1:2]; wraps naturally at depth. Lane = addr[1:0],
//    little-endian (lane 0 = bits 7:0).
//  - Byte store writes only the addressed lane; other lanes unchanged.
//  - Loads: o_ram_data = full word (regardless of i_size); o_lb_data = sign-ext(lane byte);
//    o_lbu_data = zero-ext(lane byte). Lane is taken from addr[1:0] for both sizes.
//  - Stores leave the three data outputs at their previous values. Data outputs hold
//    until the next load commit.
//  - Reset mid-operation: FSM returns to IDLE. A store not yet at its commit edge is lost
//    and no o_valid is issued.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: a word access with addr[1:0]!=0 still takes the full
//    latency. At commit: no RAM write, the data outputs are cleared to 0, and o_misalign=1
//    for the RESP cycle only.
//  LSU_MISALIGN_TRAP_EN undefined: addr[1:0] is ignored for word accesses (forced aligned).
//    o_misalign is tied to 0.
// TESTING
//  1 reset then sw 0xDEADBEEF @0x010, lw @0x010 (WAIT_CYCLES=1) -> o_valid 2 cycles after
//    accept; o_ram_data=0xDEADBEEF
//  2 sb 0x80 @0x013 over word 0x11223344, lw/lb @0x013 -> word 0x80223344;
//    o_lb_data=0xFFFFFF80; o_lbu_data=0x00000080
//  3 i_req held during busy plus a new addr -> only the first request completes;
//    exactly one o_valid per accept
//  4 sw 0xCAFEF00D @0x3FC then @0x000 (ADDR_W=10) -> distinct words; @0x400 aliases 0x000
//  5 sw 0x12345678 @0x022: with LSU_MISALIGN_TRAP_EN -> o_misalign=1, word unchanged;
//    without -> word @0x020=0x12345678, o_misalign=0
//  6 i_rst_n low one cycle after accepting sw 0xAAAA5555 @0x040 (WAIT_CYCLES=3) -> no
//    o_valid; later lw @0x040 returns the old value; outputs=0 during reset

Source files
------------

// File: rtl/data_mem_lsu.sv
// Data-memory load/store unit: word-addressed RAM with word/byte access and fixed wait states.
// Optional misaligned-word trap enabled by defining LSU_MISALIGN_TRAP_EN.
module data_mem_lsu #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_valid,
  output logic [31:0]       o_ram_data,
  output logic [31:0]       o_lb_data,
  output logic [31:0]       o_lbu_data,
  output logic              o_misalign
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned DEPTH  = 1 << WORD_W;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [31:0]       ram_data_q, ram_data_d;
  logic [31:0]       lb_data_q, lb_data_d;
  logic [31:0]       lbu_data_q, lbu_data_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       mem_q [DEPTH];

  logic              commit_c;
  logic              op_we_c;
  logic              op_size_c;
  logic [ADDR_W-1:0] op_addr_c;
  logic [31:0]       op_wdata_c;
  logic [WORD_W-1:0] idx_c;
  logic [1:0]        lane_c;
  logic [31:0]       rd_word_c;
  logic [7:0]        rd_byte_c;
  logic [31:0]       wr_word_c;
  logic              mem_we_c;
  logic              misalign_c;

  // With zero wait states the commit happens on the accept edge, so use live inputs there
  always_comb begin
    op_we_c    = (state_q == S_IDLE) ? i_we    : we_q;
    op_size_c  = (state_q == S_IDLE) ? i_size  : size_q;
    op_addr_c  = (state_q == S_IDLE) ? i_addr  : addr_q;
    op_wdata_c = (state_q == S_IDLE) ? i_wdata : wdata_q;
    idx_c      = op_addr_c[ADDR_W-1:2];
    lane_c     = op_addr_c[1:0];
    rd_word_c  = mem_q[idx_c];
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_c = !op_size_c && (lane_c != 2'b00);
`else
    misalign_c = 1'b0;
`endif
  end

  // Lane select for loads and lane merge for byte stores (little-endian)
  always_comb begin
    rd_byte_c = 8'h00;
    wr_word_c = rd_word_c;
    case (lane_c)
      2'd0: rd_byte_c = rd_word_c[7:0];
      2'd1: rd_byte_c = rd_word_c[15:8];
      2'd2: rd_byte_c = rd_word_c[23:16];
      default: rd_byte_c = rd_word_c[31:24];
    endcase
    if (op_size_c) begin
      case (lane_c)
        2'd0: wr_word_c[7:0]   = op_wdata_c[7:0];
        2'd1: wr_word_c[15:8]  = op_wdata_c[7:0];
        2'd2: wr_word_c[23:16] = op_wdata_c[7:0];
        default: wr_word_c[31:24] = op_wdata_c[7:0];
      endcase
    end else begin
      wr_word_c = op_wdata_c;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ram_data_d = ram_data_q;
    lb_data_d  = lb_data_q;
    lbu_data_d = lbu_data_q;
    misalign_d = 1'b0;
    commit_c   = 1'b0;
    mem_we_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          size_d  = i_size;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Commit: trap clears outputs; stores write RAM; loads capture all three candidates
    if (commit_c) begin
      if (misalign_c) begin
        ram_data_d = 32'h0;
        lb_data_d  = 32'h0;
        lbu_data_d = 32'h0;
        misalign_d = 1'b1;
      end else if (op_we_c) begin
        mem_we_c = 1'b1;
      end else begin
        ram_data_d = rd_word_c;
        lb_data_d  = {{24{rd_byte_c[7]}}, rd_byte_c};
        lbu_data_d = {24'h0, rd_byte_c};
      end
    end

    ready_d = (state_d == S_IDLE);
    valid_d = commit_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      ram_data_q <= 32'h0;
      lb_data_q  <= 32'h0;
      lbu_data_q <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      ram_data_q <= ram_data_d;
      lb_data_q  <= lb_data_d;
      lbu_data_q <= lbu_data_d;
      misalign_q <= misalign_d;
    end
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_ram_data = ram_data_q;
  assign o_lb_data  = lb_data_q;
  assign o_lbu_data = lbu_data_q;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: vector table through a scoreboard (1 wait state) plus
// a 3-wait-state instance for latency and mid-operation reset.
module tb_data_mem_lsu;
  localparam int unsigned AW = 10;
  localparam int unsigned W1 = 1;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req, we, size;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          o_ready, o_valid, o_misalign;
  logic [31:0]   o_ram_data, o_lb_data, o_lbu_data;

  logic          b_rst_n, b_req, b_we, b_size;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata;
  logic          b_ready, b_valid, b_misalign;
  logic [31:0]   b_ram_data, b_lb_data, b_lbu_data;

  data_mem_lsu #(.ADDR_W(AW), .WAIT_CYCLES(W1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_addr(addr), .i_wdata(wdata), .o_ready(o_ready), .o_valid(o_valid),
    .o_ram_data(o_ram_data), .o_lb_data(o_lb_data), .o_lbu_data(o_lbu_data),
    .o_misalign(o_misalign)
  );

  data_mem_lsu #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_req(b_req), .i_we(b_we), .i_size(b_size),
    .i_addr(b_addr), .i_wdata(b_wdata), .o_ready(b_ready), .o_valid(b_valid),
    .o_ram_data(b_ram_data), .o_lb_data(b_lb_data), .o_lbu_data(b_lbu_data),
    .o_misalign(b_misalign)
  );

  typedef struct {
    logic          we;
    logic          size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          trap;
    logic [31:0]   word;
    logic [31:0]   lb;
    logic [31:0]   lbu;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] word;
    logic [31:0] lb;
    logic [31:0] lbu;
    logic        mis;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sbq[$];
  vec_t vt[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic w, input logic s, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic t, input logic [31:0] wd,
                               input logic [31:0] lb, input logic [31:0] lbu);
    vec_t v;
    v.we = w; v.size = s; v.addr = a; v.wdata = d; v.trap = t;
    v.word = wd; v.lb = lb; v.lbu = lbu;
    return v;
  endfunction

  // Scoreboard: every o_valid pops one expectation
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no pending access");
      end else begin
        mon_e = sbq.pop_front();
        chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("ram_data", o_ram_data, mon_e.word);
        chk("lb_data", o_lb_data, mon_e.lb);
        chk("lbu_data", o_lbu_data, mon_e.lbu);
        chk("misalign", {31'h0, o_misalign}, {31'h0, mon_e.mis});
      end
    end
  end

  // Called at a negedge; returns at a negedge once the access has completed
  task automatic access(input logic w, input logic s, input logic [AW-1:0] a,
                        input logic [31:0] d, input exp_t e);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", 32'(o_ready), 32'd1);
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    e.cyc = cyc + int'(W1) + 1;
    sbq.push_back(e);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("valid_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic b_wait_valid(output int n);
    n = 1;
    while (!b_valid && n < 12) begin @(negedge clk); n++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e, prev;
    vec_t v;
    int   n;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = '0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_size = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, o_ready}, 32'd1);
    chk("rst_valid", {31'h0, o_valid}, 32'd0);
    chk("rst_misalign", {31'h0, o_misalign}, 32'd0);
    chk("rst_ram_data", o_ram_data, 32'h0);
    chk("rst_lb_data", o_lb_data, 32'h0);
    chk("rst_lbu_data", o_lbu_data, 32'h0);
    chk("rst_b_misalign", {31'h0, b_misalign}, 32'd0);

    vt.push_back(mkv(1, 0, 10'h010, 32'hDEADBEEF, 0, 0, 0, 0));
    vt.push_back(mkv(0, 0, 10'h010, 0, 0, 32'hDEADBEEF, 32'hFFFFFFEF, 32'h000000EF));
    vt.push_back(mkv(1, 0, 10'h010, 32'h11223344, 0, 0, 0, 0));
    vt.push_back(mkv(1, 1, 10'h013, 32'h55AAAA80, 0, 0, 0, 0));
    vt.push_back(mkv(0, 1, 10'h013, 0, 0, 32'h80223344, 32'hFFFFFF80, 32'h00000080));
    vt.push_back(mkv(0, 0, 10'h010, 0, 0, 32'h80223344, 32'h00000044, 32'h00000044));
    vt.push_back(mkv(0, 1, 10'h012, 0, 0, 32'h80223344, 32'h00000022, 32'h00000022));
    vt.push_back(mkv(1, 0, 10'h3FC, 32'hCAFEF00D, 0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 10'h000, 32'h01020304, 0, 0, 0, 0));
    vt.push_back(mkv(0, 0, 10'h3FC, 0, 0, 32'hCAFEF00D, 32'h0000000D, 32'h0000000D));
    vt.push_back(mkv(0, 0, 10'h000, 0, 0, 32'h01020304, 32'h00000004, 32'h00000004));
    vt.push_back(mkv(0, 1, 10'h3FF, 0, 0, 32'hCAFEF00D, 32'hFFFFFFCA, 32'h000000CA));
    vt.push_back(mkv(1, 0, 10'h020, 32'hA5A5A5A5, 0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 10'h100, 32'h0BADF00D, 0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 10'h022, 32'h12345678, TRAP, 0, 0, 0));
    vt.push_back(mkv(0, 0, 10'h020, 0, 0, TRAP ? 32'hA5A5A5A5 : 32'h12345678,
                     TRAP ? 32'hFFFFFFA5 : 32'h00000078, TRAP ? 32'h000000A5 : 32'h00000078));
    vt.push_back(mkv(0, 1, 10'h021, 0, 0, TRAP ? 32'hA5A5A5A5 : 32'h12345678,
                     TRAP ? 32'hFFFFFFA5 : 32'h00000056, TRAP ? 32'h000000A5 : 32'h00000056));

    // Plain stores keep the previous load data; a trapped access clears it
    prev = '{0, 32'h0, 32'h0, 32'h0, 1'b0};
    foreach (vt[i]) begin
      v = vt[i];
      if (v.we && !v.trap) begin
        e = prev;
      end else begin
        e.word = v.word; e.lb = v.lb; e.lbu = v.lbu;
      end
      e.mis = v.trap;
      e.cyc = 0;
      prev = e;
      access(v.we, v.size, v.addr, v.wdata, e);
      chk("misalign_one_cycle", {31'h0, o_misalign}, 32'd0);
    end

    // Request held through the busy period with new fields: only the first completes
    req = 1'b1; we = 1'b0; size = 1'b0; addr = 10'h010; wdata = 32'h0;
    e = '{cyc + int'(W1) + 1, 32'h80223344, 32'h00000044, 32'h00000044, 1'b0};
    sbq.push_back(e);
    @(negedge clk);
    we = 1'b1; addr = 10'h100; wdata = 32'hDEAD0000;
    n = 0;
    while (!o_valid && n < 10) begin @(negedge clk); n++; end
    req = 1'b0;
    chk("held_req_valid", {31'h0, o_valid}, 32'd1);
    repeat (4) @(negedge clk);
    chk("held_req_drained", 32'(sbq.size()), 32'd0);
    e = '{0, 32'h0BADF00D, 32'h0000000D, 32'h0000000D, 1'b0};
    access(1'b0, 1'b0, 10'h100, 32'h0, e);

    // 3-wait-state instance: latency, then reset between accept and commit
    b_req = 1'b1; b_we = 1'b1; b_size = 1'b0; b_addr = 10'h040; b_wdata = 32'h11110000;
    @(negedge clk);
    b_req = 1'b0;
    b_wait_valid(n);
    chk("b_store_latency", 32'(n), 32'd4);
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0;
    @(negedge clk);
    b_req = 1'b0;
    b_wait_valid(n);
    chk("b_load_latency", 32'(n), 32'd4);
    chk("b_load_data", b_ram_data, 32'h11110000);
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_wdata = 32'hAAAA5555;
    @(negedge clk);
    b_req = 1'b0;
    b_rst_n = 1'b0;
    #1;
    chk("b_rst_ready", {31'h0, b_ready}, 32'd1);
    chk("b_rst_valid", {31'h0, b_valid}, 32'd0);
    chk("b_rst_ram_data", b_ram_data, 32'h0);
    chk("b_rst_lbu_data", b_lbu_data, 32'h0);
    @(negedge clk);
    b_rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b_valid) n++;
    end
    chk("b_no_valid_after_reset", 32'(n), 32'd0);
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h040;
    @(negedge clk);
    b_req = 1'b0;
    b_wait_valid(n);
    chk("b_lost_store_word", b_ram_data, 32'h11110000);
    chk("b_lost_store_lbu", b_lbu_data, 32'h00000000);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
